// File: rtl/vid_cntr_unit.sv
// Pixel coordinate generator: tracks the (x,y) position of the pixel being
// requested, so a consumer can use h_cntr/v_cntr alongside in_req directly.
module vid_cntr_unit #(
  parameter int H_BITS = 12,
  parameter int V_BITS = 11
) (
  input  logic              clk,
  input  logic              reset_,
  input  logic              in_vsync,
  input  logic              in_req,
  input  logic              in_eol,
  input  logic              in_eof,
  output logic [H_BITS-1:0] h_cntr,
  output logic [V_BITS-1:0] v_cntr
);

  logic [H_BITS-1:0] h_cntr_q, h_cntr_d;
  logic [V_BITS-1:0] v_cntr_q, v_cntr_d;

  // Counters advance after the requested pixel, so the registered value is
  // always the coordinate of the pixel requested in the current cycle.
  always_comb begin
    h_cntr_d = h_cntr_q;
    v_cntr_d = v_cntr_q;
    if (in_vsync) begin
      h_cntr_d = '0;
      v_cntr_d = '0;
    end else if (in_req) begin
      if (in_eof) begin
        h_cntr_d = '0;
        v_cntr_d = '0;
      end else if (in_eol) begin
        h_cntr_d = '0;
        v_cntr_d = v_cntr_q + 1'b1;
      end else begin
        h_cntr_d = h_cntr_q + 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset_) begin
      h_cntr_q <= '0;
      v_cntr_q <= '0;
    end else begin
      h_cntr_q <= h_cntr_d;
      v_cntr_q <= v_cntr_d;
    end
  end

  assign h_cntr = h_cntr_q;
  assign v_cntr = v_cntr_q;

endmodule

// File: tb/tb_vid_cntr_unit.sv
// Scoreboard bench for vid_cntr_unit: directed scenarios plus random traffic,
// expected coordinates come from a pixel-position model of the video stream.
module tb_vid_cntr_unit;

  localparam int H_BITS = 12;
  localparam int V_BITS = 11;
  localparam int H_MOD  = 1 << H_BITS;
  localparam int V_MOD  = 1 << V_BITS;

  logic              clk = 1'b0;
  logic              reset_ = 1'b1;
  logic              in_vsync = 1'b0;
  logic              in_req = 1'b0;
  logic              in_eol = 1'b0;
  logic              in_eof = 1'b0;
  logic [H_BITS-1:0] h_cntr;
  logic [V_BITS-1:0] v_cntr;

  vid_cntr_unit #(.H_BITS(H_BITS), .V_BITS(V_BITS)) dut (
    .clk      (clk),
    .reset_   (reset_),
    .in_vsync (in_vsync),
    .in_req   (in_req),
    .in_eol   (in_eol),
    .in_eof   (in_eof),
    .h_cntr   (h_cntr),
    .v_cntr   (v_cntr)
  );

  always #5 clk = ~clk;

  typedef struct {
    int    h;
    int    v;
    string tag;
  } exp_t;

  exp_t  sb_q[$];
  int    chk_cnt  = 0;
  int    pass_cnt = 0;
  int    model_x  = 0;
  int    model_y  = 0;
  string phase    = "init";

  // One cycle of stimulus; records the position the DUT must be showing now,
  // then moves the model to the position of the next pixel.
  task automatic step(input logic rst, input logic vs, input logic rq,
                      input logic el, input logic ef);
    exp_t e;
    reset_   = rst;
    in_vsync = vs;
    in_req   = rq;
    in_eol   = el;
    in_eof   = ef;
    if (!rst) begin
      e.h = model_x;
      e.v = model_y;
      e.tag = phase;
      sb_q.push_back(e);
    end
    if (rst || vs || (rq && ef)) begin
      model_x = 0;
      model_y = 0;
    end else if (rq && el) begin
      model_x = 0;
      model_y = (model_y + 1) % V_MOD;
    end else if (rq) begin
      model_x = (model_x + 1) % H_MOD;
    end
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset(input int n);
    for (int i = 0; i < n; i++) step(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic line4(input logic last_eof);
    for (int i = 0; i < 3; i++) step(1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
    step(1'b0, 1'b0, 1'b1, 1'b1, last_eof);
  endtask

  // Monitor: every cycle out of reset the coordinates are observable.
  always @(negedge clk) begin
    if (!reset_) begin
      exp_t e;
      chk_cnt++;
      if (sb_q.size() == 0) begin
        $display("FAIL sb_underflow: got h=%0d v=%0d, required a queued expectation",
                 h_cntr, v_cntr);
      end else begin
        e = sb_q.pop_front();
        if (int'(h_cntr) == e.h && int'(v_cntr) == e.v) begin
          pass_cnt++;
          $display("chk %0d %s h=%0d v=%0d ok", chk_cnt, e.tag, h_cntr, v_cntr);
        end else begin
          $display("FAIL %s: got h=%0d v=%0d, required h=%0d v=%0d",
                   e.tag, h_cntr, v_cntr, e.h, e.v);
        end
      end
    end
  end

  initial begin
    @(posedge clk);
    #1;
    phase = "reset";
    do_reset(2);

    phase = "count5";
    for (int i = 0; i < 5; i++) step(1'b0, 1'b0, 1'b1, 1'b0, 1'b0);

    phase = "lines";
    do_reset(1);
    for (int l = 0; l < 3; l++) line4(1'b0);
    step(1'b0, 1'b0, 1'b1, 1'b0, 1'b0);

    phase = "gaps";
    do_reset(1);
    step(1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
    step(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    step(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    step(1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
    step(1'b0, 1'b0, 1'b1, 1'b0, 1'b0);

    phase = "eof_eol";
    do_reset(1);
    line4(1'b0);
    line4(1'b0);
    line4(1'b1);
    step(1'b0, 1'b0, 1'b1, 1'b0, 1'b0);

    phase = "eof_only";
    line4(1'b0);
    line4(1'b0);
    for (int i = 0; i < 3; i++) step(1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
    step(1'b0, 1'b0, 1'b1, 1'b0, 1'b1);
    step(1'b0, 1'b0, 1'b1, 1'b0, 1'b0);

    phase = "vsync";
    do_reset(1);
    for (int l = 0; l < 3; l++) line4(1'b0);
    for (int i = 0; i < 7; i++) step(1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
    step(1'b0, 1'b1, 1'b1, 1'b1, 1'b1);
    step(1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
    step(1'b0, 1'b0, 1'b1, 1'b0, 1'b0);

    phase = "idle_marks";
    step(1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
    step(1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
    step(1'b0, 1'b0, 1'b0, 1'b1, 1'b1);
    step(1'b0, 1'b0, 1'b1, 1'b0, 1'b0);

    phase = "h_wrap";
    do_reset(1);
    line4(1'b0);
    for (int i = 0; i < H_MOD + 4; i++) step(1'b0, 1'b0, 1'b1, 1'b0, 1'b0);

    phase = "mid_reset";
    do_reset(1);
    line4(1'b0);
    line4(1'b0);
    for (int i = 0; i < 10; i++) step(1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
    do_reset(1);
    step(1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
    step(1'b0, 1'b0, 1'b1, 1'b0, 1'b0);

    phase = "random";
    for (int i = 0; i < 3000; i++) begin
      step($urandom_range(0, 255) == 0, $urandom_range(0, 127) == 0,
           $urandom_range(0, 3) != 0, $urandom_range(0, 15) == 0,
           $urandom_range(0, 63) == 0);
    end

    phase = "drain";
    step(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    @(negedge clk);
    chk_cnt++;
    if (sb_q.size() == 0) pass_cnt++;
    else $display("FAIL sb_leftover: got %0d queued, required 0", sb_q.size());

    $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
    $finish;
  end

endmodule
